// File: rtl/dct2_4x4_seq_if.sv
// rtl/dct2_4x4_seq_if.sv - row-in / coefficient-column-out stream bundle for dct2_4x4_seq
interface dct2_4x4_seq_if;
    logic               in_valid;
    logic               in_ready;
    logic signed [11:0] in_data [0:3];
    logic               out_valid;
    logic               out_ready;
    logic signed [19:0] out_data [0:3];
    logic [1:0]         out_col;
    logic               out_last;
    logic               busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_col, out_last, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_col, out_last, busy
    );
endinterface

// File: rtl/dct2_4x4_seq.sv
// rtl/dct2_4x4_seq.sv - 4x4 DCT-II with one shared 4-point core, row pass then column pass
module dct2_4_1 (
    input  logic signed [11:0] x_i  [0:3],
    output logic signed [19:0] ye_o [0:1],
    output logic signed [19:0] yo_o [0:1]
);
    logic signed [19:0] s0, s1, d0, d1;

    always_comb begin
        s0 = 20'(x_i[0]) + 20'(x_i[3]);
        s1 = 20'(x_i[1]) + 20'(x_i[2]);
        d0 = 20'(x_i[0]) - 20'(x_i[3]);
        d1 = 20'(x_i[1]) - 20'(x_i[2]);
        ye_o[0] = (s0 + s1) * 20'sd64;
        ye_o[1] = (s0 - s1) * 20'sd64;
        yo_o[0] = d0 * 20'sd83 + d1 * 20'sd36;
        yo_o[1] = d0 * 20'sd36 - d1 * 20'sd83;
    end
endmodule

module dct2_4x4_seq (
    input  logic           clk,
    input  logic           rst,
    dct2_4x4_seq_if.slave  io
);
    typedef enum logic {ST_ROW, ST_COL} state_e;

    state_e             state_q;
    logic [1:0]         row_cnt_q;
    logic [2:0]         col_cnt_q;
    logic signed [11:0] buf_q [0:3][0:3];
    logic               in_ready_q;
    logic               out_valid_q;
    logic               out_last_q;
    logic               busy_q;
    logic [1:0]         out_col_q;
    logic signed [19:0] out_data_q [0:3];

    logic signed [11:0] core_x  [0:3];
    logic signed [19:0] core_ye [0:1];
    logic signed [19:0] core_yo [0:1];
    logic signed [19:0] coef    [0:3];
    logic               issue;
    logic               out_hs;

    function automatic logic signed [11:0] round_sat(input logic signed [19:0] y);
        logic signed [20:0] r;
        r = (21'(y) + 21'sd128) >>> 8;
        if (r > 21'sd2047)
            return 12'sd2047;
        else if (r < -21'sd2048)
            return -12'sd2048;
        else
            return r[11:0];
    endfunction

    // Row pass transforms the live input; column pass replays the transpose buffer.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            core_x[n] = (state_q == ST_ROW) ? io.in_data[n] : buf_q[n][col_cnt_q[1:0]];
        end
    end

    dct2_4_1 u_core (
        .x_i  (core_x),
        .ye_o (core_ye),
        .yo_o (core_yo)
    );

    assign coef[0] = core_ye[0];
    assign coef[1] = core_yo[0];
    assign coef[2] = core_ye[1];
    assign coef[3] = core_yo[1];

    assign out_hs = out_valid_q && io.out_ready;
    assign issue  = (state_q == ST_COL) && !col_cnt_q[2] && (!out_valid_q || io.out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ROW;
            row_cnt_q   <= '0;
            col_cnt_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_col_q   <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                out_data_q[k] <= '0;
            end
        end else begin
            case (state_q)
                ST_ROW: begin
                    if (io.in_valid && in_ready_q) begin
                        for (int j = 0; j < 4; j++) begin
                            buf_q[row_cnt_q][j] <= round_sat(coef[j]);
                        end
                        busy_q    <= 1'b1;
                        row_cnt_q <= row_cnt_q + 2'd1;
                        if (row_cnt_q == 2'd3) begin
                            state_q    <= ST_COL;
                            col_cnt_q  <= '0;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                ST_COL: begin
                    // A new column may be loaded on the same edge the previous one is taken.
                    if (issue) begin
                        for (int k = 0; k < 4; k++) begin
                            out_data_q[k] <= coef[k];
                        end
                        out_col_q   <= col_cnt_q[1:0];
                        out_last_q  <= (col_cnt_q == 3'd3);
                        out_valid_q <= 1'b1;
                        col_cnt_q   <= col_cnt_q + 3'd1;
                    end else if (out_hs) begin
                        out_valid_q <= 1'b0;
                    end
                    if (out_hs && out_last_q) begin
                        state_q     <= ST_ROW;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        col_cnt_q   <= '0;
                    end
                end
                default: state_q <= ST_ROW;
            endcase
        end
    end

    assign io.in_ready  = in_ready_q;
    assign io.out_valid = out_valid_q;
    assign io.out_data  = out_data_q;
    assign io.out_col   = out_col_q;
    assign io.out_last  = out_last_q;
    assign io.busy      = busy_q;
endmodule

// File: tb/tb_dct2_4x4_seq.sv
// tb/tb_dct2_4x4_seq.sv - randomized self-checking bench for dct2_4x4_seq against a matrix-form 2-D DCT model
module tb_dct2_4x4_seq;
    logic clk;
    logic rst;

    dct2_4x4_seq_if bus ();

    dct2_4x4_seq dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    int cm [4][4] = '{'{64, 64, 64, 64}, '{83, 36, -36, -83}, '{64, -64, -64, 64}, '{36, -83, 83, -36}};
    int x_t   [4][4];
    int exp_o [4][4];

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int rnd_sat(input int y);
        int r;
        r = (y + 128) >>> 8;
        if (r > 2047) r = 2047;
        if (r < -2048) r = -2048;
        return r;
    endfunction

    // exp_o[horizontal freq][vertical freq] = C * M where M[r][k] = round(C * row r)
    task automatic build_expect();
        int m [4][4];
        int acc;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) begin
                acc = 0;
                for (int n = 0; n < 4; n++) acc += cm[k][n] * x_t[r][n];
                m[r][k] = rnd_sat(acc);
            end
        for (int k = 0; k < 4; k++)
            for (int v = 0; v < 4; v++) begin
                acc = 0;
                for (int r = 0; r < 4; r++) acc += cm[v][r] * m[r][k];
                exp_o[k][v] = acc;
            end
    endtask

    task automatic fill_const(input int v);
        for (int r = 0; r < 4; r++)
            for (int n = 0; n < 4; n++) x_t[r][n] = v;
    endtask

    task automatic fill_rand();
        for (int r = 0; r < 4; r++)
            for (int n = 0; n < 4; n++) begin
                case ($urandom_range(0, 5))
                    0:       x_t[r][n] = -2048;
                    1:       x_t[r][n] = 2047;
                    default: x_t[r][n] = int'($urandom_range(0, 4095)) - 2048;
                endcase
            end
    endtask

    // rmode: 0 = out_ready always high, 1 = repeating 1,0,0,1-style toggle, 2 = random
    task automatic run_block(input int rmode, input bit hold_col, input string name);
        int  rows_sent, cols_got, cyc, t_acc4, snap_col;
        int  snap [4];
        bit  stall;
        rows_sent = 0; cols_got = 0; cyc = 0; t_acc4 = 0; snap_col = 0; stall = 1'b0;
        for (int v = 0; v < 4; v++) snap[v] = 0;
        build_expect();
        while (cols_got < 4 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (stall) begin
                for (int v = 0; v < 4; v++) chk($sformatf("%s_hold_d%0d", name, v), bus.out_data[v], snap[v]);
                chk({name, "_hold_col"}, int'(bus.out_col), snap_col);
            end
            if (rows_sent < 4) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                for (int n = 0; n < 4; n++) bus.in_data[n] = 12'(x_t[rows_sent][n]);
            end else begin
                bus.in_valid = hold_col;
                for (int n = 0; n < 4; n++) bus.in_data[n] = 12'($urandom_range(0, 4095));
            end
            case (rmode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            chk({name, "_busy"}, int'(bus.busy), (rows_sent > 0) ? 1 : 0);
            if (rows_sent < 4) begin
                chk({name, "_early_out_valid"}, int'(bus.out_valid), 0);
                chk({name, "_in_ready_row"}, int'(bus.in_ready), 1);
                if (bus.in_valid && bus.in_ready) begin
                    rows_sent++;
                    if (rows_sent == 4) t_acc4 = cyc;
                end
            end else begin
                chk({name, "_in_ready_col"}, int'(bus.in_ready), 0);
            end
            if (bus.out_valid && bus.out_ready) begin
                chk($sformatf("%s_col_idx%0d", name, cols_got), int'(bus.out_col), cols_got);
                chk($sformatf("%s_last%0d", name, cols_got), int'(bus.out_last), (cols_got == 3) ? 1 : 0);
                for (int v = 0; v < 4; v++)
                    chk($sformatf("%s_c%0d_k%0d", name, cols_got, v), bus.out_data[v], exp_o[cols_got][v]);
                if (rmode == 0) chk($sformatf("%s_lat%0d", name, cols_got), cyc - t_acc4, 2 + cols_got);
                cols_got++;
            end
            stall = bus.out_valid && !bus.out_ready;
            if (stall) begin
                for (int v = 0; v < 4; v++) snap[v] = bus.out_data[v];
                snap_col = int'(bus.out_col);
            end
        end
        chk({name, "_cols_done"}, cols_got, 4);
        @(negedge clk);
        #1;
        chk({name, "_in_ready_after"}, int'(bus.in_ready), 1);
        chk({name, "_busy_after"}, int'(bus.busy), 0);
        chk({name, "_out_valid_after"}, int'(bus.out_valid), 0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int k;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        for (int n = 0; n < 4; n++) bus.in_data[n] = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_col", int'(bus.out_col), 0);
        chk("rst_out_last", int'(bus.out_last), 0);
        chk("rst_busy", int'(bus.busy), 0);
        for (int v = 0; v < 4; v++) chk($sformatf("rst_out_d%0d", v), bus.out_data[v], 0);
        rst = 1'b0;

        fill_const(16);
        run_block(0, 1'b0, "dc16");
        chk("dc16_model_c0k0", exp_o[0][0], 4096);

        fill_const(0);
        x_t[0][0] = 256;
        run_block(0, 1'b0, "imp");
        chk("imp_model_c1k1", exp_o[1][1], 6889);

        fill_const(-2048);
        run_block(0, 1'b0, "neg");
        chk("neg_model_c0k0", exp_o[0][0], -524288);

        fill_const(0);
        x_t[0][0] = 256;
        run_block(1, 1'b0, "imp_bp");

        fill_rand();
        run_block(1, 1'b1, "hold");

        fill_rand();
        k = 0;
        for (int c = 0; c < 50 && k < 2; c++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            for (int n = 0; n < 4; n++) bus.in_data[n] = 12'(x_t[k][n]);
            #1;
            if (bus.in_valid && bus.in_ready) k++;
        end
        chk("rst_pre_rows", k, 2);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_in_ready", int'(bus.in_ready), 1);
        chk("midrst_out_valid", int'(bus.out_valid), 0);
        fill_const(16);
        run_block(0, 1'b0, "post_rst");

        for (int b = 0; b < 6; b++) begin
            fill_rand();
            run_block(2, b[0], $sformatf("rnd%0d", b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
